// File: rtl/mem_io_responder.sv
// Byte-wide memory/IO responder: 2^RAM_ADDR_W byte RAM, UART TX FIFO, RX pop port, cycle counter, stop flag.
// Latency: reads return on mem_din one cycle after the address; writes take effect at the clock edge.
// Backpressure: io_buffer_full warns FULL_MARGIN entries early; pushes into a full FIFO with no pop are dropped (tx_overflow).
module mem_io_responder #(
    parameter int RAM_ADDR_W  = 17,
    parameter int TX_DEPTH    = 8,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_pop,
    output logic        program_done,
    output logic        tx_overflow
);
    localparam int PTR_W = $clog2(TX_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [17:0] ADDR_UART = 18'h30000;
    localparam logic [17:0] ADDR_STOP = 18'h30004;

    logic [7:0]            ram [2**RAM_ADDR_W];
    logic [7:0]            fifo_mem [TX_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      tx_cnt, cnt_nxt;
    logic [31:0]           cycle_cnt, snap;
    logic [7:0]            ram_q, io_q, io_rd_dat, push_dat;
    logic                  rd_is_ram;
    logic                  io_sel, ram_rd, io_rd, push_en, pop_en, push_ok, fifo_full;
    logic [17:0]           addr;
    logic [RAM_ADDR_W-1:0] ram_idx;
    logic [13:0]           unused_addr_hi;

    assign addr           = mem_a[17:0];
    assign unused_addr_hi = mem_a[31:18];
    assign ram_idx        = mem_a[RAM_ADDR_W-1:0];
    assign io_sel         = (addr[17:16] == 2'b11);
    assign ram_rd         = !io_sel && !mem_wr;
    assign io_rd          = io_sel && !mem_wr;

    assign rx_pop = rst_n_in && io_rd && (addr == ADDR_UART) && rx_valid;

    // The stop address doubles as a terminator push so the UART side sees end-of-stream.
    assign push_en  = io_sel && mem_wr &&
                      (((addr == ADDR_UART) && (mem_dout != 8'h00)) || (addr == ADDR_STOP));
    assign push_dat = (addr == ADDR_STOP) ? 8'h00 : mem_dout;
    assign tx_valid  = (tx_cnt != '0);
    assign tx_data   = tx_valid ? fifo_mem[rd_ptr] : 8'h00;
    assign pop_en    = tx_valid && tx_ready;
    assign fifo_full = (tx_cnt == CNT_W'(TX_DEPTH));
    assign push_ok   = push_en && (!fifo_full || pop_en);

    always_comb begin
        cnt_nxt = tx_cnt;
        if (push_ok && !pop_en) begin
            cnt_nxt = tx_cnt + CNT_W'(1);
        end else if (!push_ok && pop_en) begin
            cnt_nxt = tx_cnt - CNT_W'(1);
        end
    end

    always_comb begin
        io_rd_dat = 8'h00;
        case (addr)
            18'h30000: io_rd_dat = rx_valid ? rx_data : 8'h00;
            18'h30004: io_rd_dat = cycle_cnt[7:0];
            18'h30005: io_rd_dat = snap[15:8];
            18'h30006: io_rd_dat = snap[23:16];
            18'h30007: io_rd_dat = snap[31:24];
            default:   io_rd_dat = 8'h00;
        endcase
    end

    // Storage arrays carry no reset so they can map onto block RAM.
    always_ff @(posedge clk_in) begin
        if (mem_wr && !io_sel) begin
            ram[ram_idx] <= mem_dout;
        end
        if (ram_rd) begin
            ram_q <= ram[ram_idx];
        end
        if (push_ok) begin
            fifo_mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rd_is_ram      <= 1'b0;
            io_q           <= 8'h00;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            tx_cnt         <= '0;
            io_buffer_full <= 1'b0;
            tx_overflow    <= 1'b0;
            program_done   <= 1'b0;
            cycle_cnt      <= '0;
            snap           <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (ram_rd) begin
                rd_is_ram <= 1'b1;
            end else if (io_rd) begin
                rd_is_ram <= 1'b0;
                io_q      <= io_rd_dat;
                if (addr == ADDR_STOP) begin
                    snap <= cycle_cnt;
                end
            end
            if (io_sel && mem_wr && (addr == ADDR_STOP)) begin
                program_done <= 1'b1;
            end
            if (push_en && !push_ok) begin
                tx_overflow <= 1'b1;
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            tx_cnt         <= cnt_nxt;
            io_buffer_full <= (cnt_nxt >= CNT_W'(TX_DEPTH - FULL_MARGIN));
        end
    end

    // rd_is_ram resets to 0 and io_q to 0, so an in-flight read is discarded by reset.
    assign mem_din = rd_is_ram ? ram_q : io_q;
endmodule

// File: tb/tb_mem_io_responder.sv
// Randomized and directed bench for mem_io_responder against a queue/array reference model.
module tb_mem_io_responder;
    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_pop;
    logic        program_done;
    logic        tx_overflow;

    mem_io_responder dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .mem_a(mem_a), .mem_dout(mem_dout),
        .mem_wr(mem_wr), .mem_din(mem_din), .io_buffer_full(io_buffer_full),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_pop(rx_pop), .program_done(program_done),
        .tx_overflow(tx_overflow)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [7:0]  m_q[$];
    logic [7:0]  m_ram[int];
    logic [7:0]  m_din;
    logic [31:0] m_cnt;
    logic [31:0] m_snap;
    logic        m_ovf, m_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic [31:0] a, input logic [7:0] d);
        mem_wr = wr;
        mem_a = a;
        mem_dout = d;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_din = 8'h00;
        m_cnt = 32'd0;
        m_snap = 32'd0;
        m_ovf = 1'b0;
        m_done = 1'b0;
    endtask

    // Applies current inputs for one clock, advances the model, compares all outputs.
    task automatic step();
        logic [17:0] a;
        logic        io, pop, push;
        logic [7:0]  pd;
        int          k;
        #1;
        a = mem_a[17:0];
        io = (a[17:16] == 2'b11);
        k = int'(mem_a[16:0]);
        check("rx_pop", rx_pop, io && !mem_wr && a == 18'h30000 && rx_valid);
        pop = (m_q.size() != 0) && tx_ready;
        push = 1'b0;
        pd = 8'h00;
        if (mem_wr) begin
            if (!io) m_ram[k] = mem_dout;
            else if (a == 18'h30000 && mem_dout != 8'h00) begin push = 1'b1; pd = mem_dout; end
            else if (a == 18'h30004) begin push = 1'b1; pd = 8'h00; m_done = 1'b1; end
        end else if (!io) begin
            m_din = m_ram.exists(k) ? m_ram[k] : 8'h00;
        end else begin
            case (a)
                18'h30000: m_din = rx_valid ? rx_data : 8'h00;
                18'h30004: begin m_din = m_cnt[7:0]; m_snap = m_cnt; end
                18'h30005: m_din = m_snap[15:8];
                18'h30006: m_din = m_snap[23:16];
                18'h30007: m_din = m_snap[31:24];
                default:   m_din = 8'h00;
            endcase
        end
        @(posedge clk_in);
        m_cnt = m_cnt + 32'd1;
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < 8) m_q.push_back(pd);
            else m_ovf = 1'b1;
        end
        #1;
        check("mem_din", mem_din, m_din);
        check("tx_valid", tx_valid, m_q.size() != 0);
        if (m_q.size() != 0) check("tx_data", tx_data, m_q[0]);
        check("io_buffer_full", io_buffer_full, m_q.size() >= 6);
        check("tx_overflow", tx_overflow, m_ovf);
        check("program_done", program_done, m_done);
    endtask

    // Asserts reset between edges and checks that outputs clear without a clock.
    task automatic do_reset();
        drive(1'b0, 32'h0003_0000, 8'h00);
        rx_valid = 1'b1;
        rx_data = 8'h55;
        rst_n_in = 1'b0;
        #1;
        check("rst_mem_din", mem_din, 8'h00);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_rx_pop", rx_pop, 1'b0);
        check("rst_done", program_done, 1'b0);
        check("rst_ovf", tx_overflow, 1'b0);
        check("rst_ibf", io_buffer_full, 1'b0);
        model_reset();
        @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        rx_valid = 1'b0;
        drive(1'b0, 32'h0003_000C, 8'h00);
    endtask

    initial begin
        logic [31:0] r, snap_v;
        logic [7:0]  b;
        int          op, idx;
        rst_n_in = 1'b0;
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        drive(1'b0, 32'h0003_000C, 8'h00);
        do_reset();

        // RAM write-then-read and preload read
        drive(1'b1, 32'h0000_0011, 8'h3C); step();
        drive(1'b1, 32'h0000_0010, 8'hA5); step();
        drive(1'b0, 32'h0000_0010, 8'h00); step();
        check("ram_rd_A5", mem_din, 8'hA5);
        drive(1'b0, 32'hFFFC_0011, 8'h00); step();
        check("ram_rd_3C_hi_ignored", mem_din, 8'h3C);

        // TX 'H','i', then 0x00 which must not be pushed
        tx_ready = 1'b1;
        drive(1'b1, 32'h0003_0000, 8'h48); step();
        check("tx_H", tx_data, 8'h48);
        drive(1'b1, 32'h0003_0000, 8'h69); step();
        check("tx_i", tx_data, 8'h69);
        drive(1'b1, 32'h0003_0000, 8'h00); step();
        check("tx_zero_dropped", tx_valid, 1'b0);

        // RX pop with and without valid
        rx_valid = 1'b1; rx_data = 8'h7A;
        drive(1'b0, 32'h0003_0000, 8'h00); step();
        check("rx_7A", mem_din, 8'h7A);
        rx_valid = 1'b0;
        step();
        check("rx_empty", mem_din, 8'h00);

        // Fill with tx_ready low, overflow, then push+pop while full
        tx_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 32'h0003_0000, 8'(i)); step();
            if (i == 5) check("ibf_at_5", io_buffer_full, 1'b0);
            if (i == 6) check("ibf_at_6", io_buffer_full, 1'b1);
        end
        drive(1'b1, 32'h0003_0000, 8'h09); step();
        check("ovf_9th", tx_overflow, 1'b1);
        tx_ready = 1'b1;
        drive(1'b1, 32'h0003_0000, 8'h99); step();
        check("full_pushpop_head", tx_data, 8'h02);
        drive(1'b0, 32'h0003_000C, 8'h00);
        for (int i = 0; i < 10; i++) step();

        // Stop flag and terminator byte
        tx_ready = 1'b0;
        drive(1'b1, 32'h0003_0004, 8'hEE); step();
        check("done_set", program_done, 1'b1);
        check("done_term", tx_data, 8'h00);
        check("done_term_vld", tx_valid, 1'b1);
        drive(1'b1, 32'h0003_0040, 8'h11); step();
        drive(1'b0, 32'h0000_0010, 8'h00); step();

        // Reset in the middle of traffic
        do_reset();

        // Counter snapshot after 1000 cycles
        for (int i = 0; i < 1000; i++) step();
        drive(1'b0, 32'h0003_0004, 8'h00); step();
        snap_v[7:0] = mem_din;
        drive(1'b0, 32'h0003_0005, 8'h00); step();
        snap_v[15:8] = mem_din;
        drive(1'b0, 32'h0003_0006, 8'h00); step();
        snap_v[23:16] = mem_din;
        drive(1'b0, 32'h0003_0007, 8'h00); step();
        snap_v[31:24] = mem_din;
        check("snapshot_1000", snap_v, 32'd1000);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            r = $urandom();
            tx_ready = ($urandom_range(0, 1) == 1);
            rx_valid = ($urandom_range(0, 1) == 1);
            rx_data = 8'($urandom());
            b = 8'($urandom());
            if ($urandom_range(0, 3) == 0) b = 8'h00;
            op = $urandom_range(0, 9);
            idx = $urandom_range(0, 63);
            if (op == 4 || op == 5) begin
                if (!m_ram.exists(idx)) op = 0;
            end
            case (op)
                0, 1, 2, 3: drive(1'b1, {r[31:18], r[17], 1'b0, 10'd0, 6'(idx)}, b);
                4, 5:       drive(1'b0, {r[31:18], r[17], 1'b0, 10'd0, 6'(idx)}, b);
                6:          drive(1'b1, {r[31:18], 18'h30000}, b);
                7:          drive(1'b0, {r[31:18], 18'h30000}, b);
                8:          drive(1'b0, {r[31:18], 2'b11, 13'd0, 3'($urandom_range(0, 7))}, b);
                default: begin
                    if ($urandom_range(0, 19) == 0) drive(1'b1, {r[31:18], 18'h30004}, b);
                    else drive(1'b1, {r[31:18], 2'b11, 16'($urandom_range(8, 65535))}, b);
                end
            endcase
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
